// File: rtl/vec_mul_wide.sv
// Element-wise vector multiplier / multiply-accumulator feeding the modular-reduction stage.
// P lanes are updated per cycle into a persistent signed accumulator bank.

module vec_mul_wide #(
    parameter int unsigned N  = 8,
    parameter int unsigned W  = 16,
    parameter int unsigned WW = 2 * W,
    parameter int unsigned P  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [N-1:0][W-1:0]    in_a,
    input  logic [N-1:0][W-1:0]    in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0][WW-1:0]   out_vec,
    output logic                   busy
);

    localparam int unsigned G  = N / P;
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] LastGrp = GW'(G - 1);

    localparam logic [1:0] OpMul  = 2'b00;
    localparam logic [1:0] OpMac  = 2'b01;
    localparam logic [1:0] OpMsub = 2'b10;
    localparam logic [1:0] OpClr  = 2'b11;

    generate
        if (P < 1 || P > N || (N % P) != 0) begin : g_bad_p
            $error("vec_mul_wide: P must divide N and satisfy 1 <= P <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          grp_q, grp_d;
    logic [1:0]             op_q;
    logic [N-1:0][W-1:0]    a_q, b_q;
    logic [N-1:0][WW-1:0]   acc_q, acc_d;

    logic                   accept;
    logic [P-1:0][W-1:0]    a_sel, b_sel;
    logic [P-1:0][WW-1:0]   acc_sel, prod, lane_new;

    assign in_ready  = (state_q == StIdle) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q != StIdle);
    assign out_vec   = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCompute;
                    grp_d   = '0;
                end
            end
            StCompute: begin
                grp_d = grp_q + 1'b1;
                if (grp_q == LastGrp) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operands are captured once so later input changes cannot disturb an operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OpMul;
            a_q   <= '0;
            b_q   <= '0;
            grp_q <= '0;
            acc_q <= '0;
        end else begin
            if (accept) begin
                op_q <= in_op;
                a_q  <= in_a;
                b_q  <= in_b;
            end
            grp_q <= grp_d;
            acc_q <= acc_d;
        end
    end

    // Steer the active group of P lanes onto P shared multipliers.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        acc_sel = '0;
        for (int g = 0; g < int'(G); g++) begin
            if (grp_q == GW'(g)) begin
                for (int j = 0; j < int'(P); j++) begin
                    a_sel[j]   = a_q[g*P+j];
                    b_sel[j]   = b_q[g*P+j];
                    acc_sel[j] = acc_q[g*P+j];
                end
            end
        end
    end

    always_comb begin
        prod     = '0;
        lane_new = '0;
        for (int j = 0; j < int'(P); j++) begin
            prod[j] = WW'(a_sel[j]) * WW'(b_sel[j]);
            unique case (op_q)
                OpMul:   lane_new[j] = prod[j];
                OpMac:   lane_new[j] = acc_sel[j] + prod[j];
                OpMsub:  lane_new[j] = acc_sel[j] - prod[j];
                OpClr:   lane_new[j] = '0;
                default: lane_new[j] = '0;
            endcase
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (state_q == StCompute) begin
            for (int i = 0; i < int'(N); i++) begin
                if (grp_q == GW'(i / P)) begin
                    acc_d[i] = lane_new[i % P];
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_mul_wide.sv
// Self-checking bench for vec_mul_wide: directed vectors with literal expectations plus
// an operation-level accumulator model checked on every cycle out_valid is high.

module tb_vec_mul_wide;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 16;
    localparam int unsigned WW = 32;
    localparam int unsigned P  = 4;

    typedef logic [N-1:0][W-1:0]  vec_t;
    typedef logic [N-1:0][WW-1:0] wvec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    vec_t       in_a;
    vec_t       in_b;
    logic       out_valid;
    logic       out_ready;
    wvec_t      out_vec;
    logic       busy;

    vec_mul_wide #(.N(N), .W(W), .WW(WW), .P(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_v(input string name, input wvec_t act, input wvec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t vfill(input logic [W-1:0] v);
        vec_t r;
        for (int i = 0; i < int'(N); i++) r[i] = v;
        return r;
    endfunction

    function automatic wvec_t wfill(input logic [WW-1:0] v);
        wvec_t r;
        for (int i = 0; i < int'(N); i++) r[i] = v;
        return r;
    endfunction

    // Operation-level model: whole op applied at accept, result queued until handshake.
    wvec_t m_acc;
    wvec_t exp_q[$];
    int    n_acc = 0;
    int    n_hs  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = '0;
            exp_q.delete();
            n_acc = 0;
            n_hs  = 0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_hs++;
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < int'(N); i++) begin
                    longint unsigned pr;
                    pr = 64'(in_a[i]) * 64'(in_b[i]);
                    case (in_op)
                        2'b00:   m_acc[i] = WW'(pr);
                        2'b01:   m_acc[i] = m_acc[i] + WW'(pr);
                        2'b10:   m_acc[i] = m_acc[i] - WW'(pr);
                        default: m_acc[i] = '0;
                    endcase
                end
                exp_q.push_back(m_acc);
                n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk_i("no_x_outputs", longint'($isunknown({in_ready, out_valid, busy, out_vec})), 0);
            if (out_valid) begin
                chk_i("pending_ops", exp_q.size(), 1);
                if (exp_q.size() > 0) chk_v("out_vec_model", out_vec, exp_q[0]);
            end
        end
    end

    task automatic send(input logic [1:0] op, input vec_t a, input vec_t b, output int lat);
        int prev;
        int g;
        @(negedge clk);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        prev     = n_acc;
        g        = 0;
        do begin
            @(negedge clk);
            g++;
        end while (n_acc == prev && g < 50);
        in_valid = 1'b0;
        chk_i("accept", n_acc - prev, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk_i("ready_low_in_hold", in_ready, 0);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_i("idle_ready_after_hs", in_ready, 1);
        chk_i("valid_clear_after_hs", out_valid, 0);
    endtask

    initial begin
        int    lat;
        int    prev;
        int    g;
        vec_t  va;
        wvec_t ew;
        wvec_t snap;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_i("rst_out_valid", out_valid, 0);
        chk_i("rst_busy", busy, 0);
        chk_i("rst_in_ready", in_ready, 0);
        chk_v("rst_out_vec", out_vec, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_i("idle_in_ready", in_ready, 1);

        // MUL ramp: latency and literal lane values
        for (int i = 0; i < int'(N); i++) begin
            va[i] = W'(i + 1);
            ew[i] = WW'(1000 * (i + 1));
        end
        send(2'b00, va, vfill(16'd1000), lat);
        chk_i("mul_latency", lat, 2);
        chk_i("busy_in_hold", busy, 1);
        chk_v("mul_ramp", out_vec, ew);
        finish_op();

        send(2'b00, vfill(16'hFFFF), vfill(16'hFFFF), lat);
        chk_v("mul_max", out_vec, wfill(32'hFFFE0001));
        finish_op();

        send(2'b00, vfill(16'd3), vfill(16'd5), lat);
        chk_v("chain_mul", out_vec, wfill(32'd15));
        finish_op();
        send(2'b01, vfill(16'd2), vfill(16'd7), lat);
        chk_v("chain_mac", out_vec, wfill(32'd29));
        finish_op();
        send(2'b10, vfill(16'd10), vfill(16'd4), lat);
        chk_v("chain_msub", out_vec, wfill(32'hFFFFFFF5));
        finish_op();
        send(2'b11, vfill(16'd9), vfill(16'd9), lat);
        chk_v("chain_clr", out_vec, '0);
        finish_op();

        // Backpressure: HOLD must be immune to input activity
        for (int i = 0; i < int'(N); i++) va[i] = W'(3 * i + 7);
        send(2'b00, va, vfill(16'd100), lat);
        snap = out_vec;
        prev = n_acc;
        for (int k = 0; k < 10; k++) begin
            in_a     = vfill(W'($urandom));
            in_b     = vfill(W'($urandom));
            in_valid = ~in_valid;
            @(negedge clk);
            chk_v("hold_vec_stable", out_vec, snap);
            chk_i("hold_valid_stable", out_valid, 1);
        end
        in_valid = 1'b0;
        chk_i("hold_no_accept", n_acc - prev, 0);
        finish_op();

        // Reset mid-COMPUTE
        @(negedge clk);
        in_op    = 2'b01;
        in_a     = vfill(16'd5);
        in_b     = vfill(16'd5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_i("midrst_out_valid", out_valid, 0);
        chk_v("midrst_out_vec", out_vec, '0);
        chk_i("midrst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b01, vfill(16'd1), vfill(16'd1), lat);
        chk_v("post_rst_mac", out_vec, wfill(32'd1));
        finish_op();

        // Randomised back-to-back operations with random backpressure
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < int'(N); i++) begin
                in_a[i] = W'($urandom);
                in_b[i] = W'($urandom);
            end
            in_op    = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            prev     = n_acc;
            g        = 0;
            while (n_acc == prev && g < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                g++;
            end
            chk_i("rand_accept", n_acc - prev, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (n_hs != n_acc && g < 50) begin
            @(negedge clk);
            g++;
        end
        out_ready = 1'b0;
        chk_i("rand_handshakes", n_hs, n_acc);
        chk_i("rand_queue_empty", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vec_mul_wide.md
Name: vec_mul_wide

Overview:
- Sequential element-wise vector multiplier / multiply-accumulator; sits directly upstream of the vector modular-reduction stage and produces its wide_vec_t input.
- Takes two residue vectors (vec_t) and computes N double-width signed lane results into an internal accumulator bank, P lanes per cycle.
- Results are presented on a valid/ready output; the accumulator persists across operations so multiply-add chains run before a single reduction.

Parameters:
- N, N_SLOTS_L, number of lanes per vector.
- W, W_BITS_L, operand word width (word_t).
- WW, 2*W_BITS_L, accumulator/output lane width, signed two's complement.
- P, 4, lanes processed per cycle. Elaboration error unless N % P == 0 and 1 <= P <= N.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  2  00 MUL, 01 MAC, 10 MSUB, 11 CLR.
- in_a  in  vec_t (N x W)  operand A, unsigned residues.
- in_b  in  vec_t (N x W)  operand B, unsigned residues.
- out_valid  out  1  out_vec holds a completed result.
- out_ready  in  1  downstream accepts the result.
- out_vec  out  wide_vec_t (N x WW)  accumulator contents, signed.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, COMPUTE, HOLD. Reset (rst_n low, async): state=IDLE, all accumulator lanes=0, lane index=0, out_valid=0, busy=0.
- in_ready = (state==IDLE) && rst_n. It is low in COMPUTE and HOLD; there is no accept in the same cycle as an output handshake.
- IDLE: on in_valid && in_ready, latch in_a, in_b and in_op into operand registers, set idx=0, go to COMPUTE. Later changes on in_* have no effect.
- COMPUTE: each cycle, for lanes i in idx..idx+P-1:
  - MUL: acc[i] = a[i]*b[i]
  - MAC: acc[i] = acc[i] + a[i]*b[i]
  - MSUB: acc[i] = acc[i] - a[i]*b[i]
  - CLR: acc[i] = 0
  - Then idx += P. After the cycle that processes lanes N-P..N-1, go to HOLD with out_valid=1.
- Latency: if accepted on edge k, out_valid is high after edge k+N/P. Throughput is one operation per N/P+2 cycles with out_ready held high.
- HOLD: out_valid=1 and out_vec=acc, both stable until out_valid && out_ready. The handshake clears out_valid and returns to IDLE. The accumulator is NOT cleared.
- out_vec is driven continuously from acc in all states. It is meaningful only while out_valid=1; during COMPUTE, lanes are partially updated.
- Arithmetic:
  - Product is the unsigned W x W multiply, zero-extended to WW.
  - Add/sub is performed on WW-bit two's complement and wraps modulo 2^WW with no saturation and no flag.
  - For Q < 2^(W-1), a single MUL is always non-negative as signed WW.
  - MSUB may go negative; the downstream reduction handles negative values.
- Reset mid-operation (any state): immediate return to reset values. The in-flight operation and accumulator contents are lost.
- in_valid while not ready: ignored, and the request is not queued.
- No X on any output after reset.

Test Plan:
- Reset then MUL with N=8, P=4, W=16, a[i]=i+1, b[i]=1000 -> out_valid exactly 2 cycles after accept edge; out_vec[i]=1000*(i+1); in_ready=0 until handshake.
- MUL a=b=all 16'hFFFF (WW=32) -> every lane = 32'hFFFE0001, with no sign-extension artefact.
- MUL a=3,b=5 then MAC a=2,b=7 -> lanes 29. Then MSUB a=10,b=4 -> lanes -11 (32'hFFFFFFF5). Then CLR -> lanes 0.
- Hold out_ready=0 for 10 cycles in HOLD, toggling in_a/in_b/in_valid -> out_vec and out_valid unchanged, no accept. Raise out_ready -> one-cycle handshake, IDLE next cycle.
- Assert rst_n low one cycle after acceptance (mid COMPUTE) -> out_valid=0, acc=0 immediately. Next MAC a=1,b=1 yields lanes 1.
- Randomised back-to-back ops with random out_ready -> out_vec matches a reference model mod 2^WW; every accepted op produces exactly one output handshake.
